// File: rtl/usr_pkg.sv
// rtl/usr_pkg.sv - opcodes, FSM encoding and helpers for the universal shift register
//
// Purpose : shared definitions for param_universal_shift_reg and usr_step.
// Contents: USR_* opcode localparams, usr_state_t FSM encoding,
//           usr_is_shift() classifies ops that consume RUN cycles.
package usr_pkg;

  localparam logic [2:0] USR_HOLD  = 3'b000;
  localparam logic [2:0] USR_SHL   = 3'b001;
  localparam logic [2:0] USR_SHR   = 3'b010;
  localparam logic [2:0] USR_SAR   = 3'b011;
  localparam logic [2:0] USR_ROL   = 3'b100;
  localparam logic [2:0] USR_ROR   = 3'b101;
  localparam logic [2:0] USR_LOAD  = 3'b110;
  localparam logic [2:0] USR_CLEAR = 3'b111;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } usr_state_t;

  // Shift and rotate ops step once per RUN cycle; everything else completes on accept.
  function automatic logic usr_is_shift(input logic [2:0] op);
    return (op != USR_HOLD) && (op != USR_LOAD) && (op != USR_CLEAR);
  endfunction

endpackage

// File: rtl/usr_step.sv
// rtl/usr_step.sv - one 1-bit shift/rotate step of the universal shift register
//
// Purpose : combinational next-value logic for a single step.
// Ports   : op      in  3      opcode (only shift/rotate ops change q)
//           q       in  WIDTH  current register value
//           sin     in  1      serial input (used by SHL/SHR only)
//           q_next  out WIDTH  value after one step
//           out_bit out 1      bit leaving the register on this step
module usr_step
  import usr_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] q,
  input  logic             sin,
  output logic [WIDTH-1:0] q_next,
  output logic             out_bit
);

  always_comb begin
    q_next  = q;
    out_bit = 1'b0;
    case (op)
      USR_SHL: begin
        q_next  = {q[WIDTH-2:0], sin};
        out_bit = q[WIDTH-1];
      end
      USR_SHR: begin
        q_next  = {sin, q[WIDTH-1:1]};
        out_bit = q[0];
      end
      USR_SAR: begin
        q_next  = {q[WIDTH-1], q[WIDTH-1:1]};
        out_bit = q[0];
      end
      USR_ROL: begin
        q_next  = {q[WIDTH-2:0], q[WIDTH-1]};
        out_bit = q[WIDTH-1];
      end
      USR_ROR: begin
        q_next  = {q[0], q[WIDTH-1:1]};
        out_bit = q[0];
      end
      default: begin
        q_next  = q;
        out_bit = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/param_universal_shift_reg.sv
// rtl/param_universal_shift_reg.sv - command-driven parametrised universal shift register
//
// Purpose : accepts one command at a time over a valid/ready handshake and
//           executes HOLD/LOAD/CLEAR immediately or counted shift/rotate ops
//           one step per clock in RUN.
// Ports   : clk        in  1      clock, rising edge
//           rst_n      in  1      asynchronous active-low reset
//           cmd_valid  in  1      command present
//           cmd_ready  out 1      high in IDLE only
//           cmd_op     in  3      opcode (usr_pkg USR_*)
//           cmd_cnt    in  CNT_W  step count for shift/rotate ops
//           din        in  WIDTH  parallel load data
//           sin        in  1      serial input, sampled every RUN step
//           dout       out WIDTH  register contents
//           sout       out 1      bit leaving on the most recent step
//           busy       out 1      high while in RUN
//           done       out 1      one-cycle completion pulse
// WIDTH must be at least 2.
module param_universal_shift_reg
  import usr_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter int               CNT_W     = $clog2(WIDTH) + 1,
  parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [CNT_W-1:0] cmd_cnt,
  input  logic [WIDTH-1:0] din,
  input  logic             sin,
  output logic [WIDTH-1:0] dout,
  output logic             sout,
  output logic             busy,
  output logic             done
);

  usr_state_t       state;
  usr_state_t       state_nxt;
  logic [CNT_W-1:0] cnt_q;
  logic [2:0]       op_q;
  logic             accept;
  logic             start_run;
  logic             last_step;
  logic [WIDTH-1:0] step_q;
  logic             step_bit;

  assign cmd_ready = (state == ST_IDLE);
  assign busy      = (state == ST_RUN);
  assign accept    = cmd_valid && cmd_ready;

  // A shift with a zero count behaves like HOLD: no RUN cycles at all.
  assign start_run = accept && usr_is_shift(cmd_op) && (cmd_cnt != '0);
  assign last_step = (state == ST_RUN) && (cnt_q == CNT_W'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (start_run) state_nxt = ST_RUN;
      ST_RUN:  if (last_step) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // The step unit always sees the latched op, so cmd_op may change freely during RUN.
  usr_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .op     (op_q),
    .q      (dout),
    .sin    (sin),
    .q_next (step_q),
    .out_bit(step_bit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout  <= RESET_VAL;
      sout  <= 1'b0;
      done  <= 1'b0;
      cnt_q <= '0;
      op_q  <= USR_HOLD;
    end else begin
      done <= 1'b0;
      if (state == ST_RUN) begin
        dout  <= step_q;
        sout  <= step_bit;
        cnt_q <= cnt_q - CNT_W'(1);
        if (last_step) begin
          done <= 1'b1;
        end
      end else if (accept) begin
        if (start_run) begin
          cnt_q <= cmd_cnt;
          op_q  <= cmd_op;
        end else begin
          // Immediate ops: sout deliberately untouched.
          done <= 1'b1;
          case (cmd_op)
            USR_LOAD:  dout <= din;
            USR_CLEAR: dout <= '0;
            default:   dout <= dout;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_param_universal_shift_reg.sv
// tb/tb_param_universal_shift_reg.sv - scoreboard bench for param_universal_shift_reg
module tb_param_universal_shift_reg;

  localparam logic [2:0] OP_HOLD  = 3'b000;
  localparam logic [2:0] OP_SHL   = 3'b001;
  localparam logic [2:0] OP_SHR   = 3'b010;
  localparam logic [2:0] OP_SAR   = 3'b011;
  localparam logic [2:0] OP_ROL   = 3'b100;
  localparam logic [2:0] OP_ROR   = 3'b101;
  localparam logic [2:0] OP_LOAD  = 3'b110;
  localparam logic [2:0] OP_CLEAR = 3'b111;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [2:0] cmd_op = 3'b000;
  logic [3:0] cmd_cnt = 4'd0;
  logic [7:0] din = 8'h00;
  logic       sin = 1'b0;
  logic [7:0] dout;
  logic       sout;
  logic       busy;
  logic       done;

  typedef struct {
    string      tag;
    logic [7:0] d;
    logic       s;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;

  param_universal_shift_reg #(.WIDTH(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_op   (cmd_op),
    .cmd_cnt  (cmd_cnt),
    .din      (din),
    .sin      (sin),
    .dout     (dout),
    .sout     (sout),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input string tag, input logic [7:0] d, input logic s);
    exp_t e;
    e.tag = tag;
    e.d   = d;
    e.s   = s;
    sb.push_back(e);
  endtask

  // Offer a command at a negedge, hold until accepted, drop valid just after the accept edge.
  task automatic send(input logic [2:0] op, input logic [3:0] cnt, input logic [7:0] d);
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_cnt   = cnt;
    din       = d;
    for (int i = 0; i < 50; i++) begin
      if (cmd_ready) break;
      @(negedge clk);
    end
    if (!cmd_ready) chk("accept_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  // Wait for done, pop the scoreboard and compare; exp_busy < 0 skips the busy-length check.
  task automatic wait_done(input int exp_busy, input bit tog);
    int b    = 0;
    bit seen = 1'b0;
    exp_t e;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
      else if (busy) b++;
      if (tog) sin = ~sin;
    end
    if (!seen) begin
      chk("done_timeout", 32'd0, 32'd1);
    end else if (sb.size() == 0) begin
      chk("sb_empty", 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      chk({e.tag, "_dout"}, 32'(dout), 32'(e.d));
      chk({e.tag, "_sout"}, 32'(sout), 32'(e.s));
      chk({e.tag, "_ready"}, 32'(cmd_ready), 32'd1);
      if (exp_busy >= 0) chk({e.tag, "_busy_cycles"}, 32'(b), 32'(exp_busy));
    end
  endtask

  // Net effect of n (>0) steps with a constant sin; returns {sout, dout}.
  function automatic logic [8:0] model(input logic [2:0] op, input logic [7:0] q,
                                       input int n, input logic s);
    logic [31:0] e;
    logic [47:0] x;
    logic [15:0] r;
    int k;
    case (op)
      OP_SHL: begin
        e = ({24'd0, q} << n) | (s ? ((32'd1 << n) - 32'd1) : 32'd0);
        return {e[8], e[7:0]};
      end
      OP_SHR, OP_SAR: begin
        logic f;
        f = (op == OP_SAR) ? q[7] : s;
        x = {{24{f}}, q, 16'd0} >> n;
        return {x[15], x[23:16]};
      end
      OP_ROL: begin
        k = n % 8;
        r = {q, q} << k;
        return {r[8], r[15:8]};
      end
      default: begin
        k = n % 8;
        r = {q, q} >> k;
        return {r[7], r[7:0]};
      end
    endcase
  endfunction

  initial begin
    logic [7:0] q0;
    logic [2:0] op;
    int n;
    int cnt_rdy_low;
    int dones;
    logic [8:0] m;
    logic [2:0] rops [5];
    rops = '{OP_SHL, OP_SHR, OP_SAR, OP_ROL, OP_ROR};

    repeat (2) @(negedge clk);
    chk("rst_dout", 32'(dout), 32'h00);
    chk("rst_sout", 32'(sout), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_ready", 32'(cmd_ready), 32'd1);
    rst_n = 1'b1;

    push("load_a5", 8'hA5, 1'b0);
    send(OP_LOAD, 4'd0, 8'hA5);
    wait_done(0, 1'b0);

    sin = 1'b1;
    push("shl3", 8'h2F, 1'b1);
    send(OP_SHL, 4'd3, 8'h00);
    wait_done(3, 1'b0);
    @(negedge clk);
    chk("shl3_done_one_cycle", 32'(done), 32'd0);

    push("load_81", 8'h81, 1'b1);
    send(OP_LOAD, 4'd0, 8'h81);
    wait_done(0, 1'b0);
    push("sar2", 8'hE0, 1'b0);
    send(OP_SAR, 4'd2, 8'h00);
    wait_done(2, 1'b1);

    push("load_01", 8'h01, 1'b0);
    send(OP_LOAD, 4'd0, 8'h01);
    wait_done(0, 1'b0);
    push("ror9", 8'h80, 1'b1);
    send(OP_ROR, 4'd9, 8'h00);
    wait_done(9, 1'b0);

    // LOAD offered while SHL 4 runs: must wait, then be taken on the done cycle.
    sin = 1'b0;
    push("shl4", 8'h00, 1'b0);
    send(OP_SHL, 4'd4, 8'h00);
    cmd_valid = 1'b1;
    cmd_op    = OP_LOAD;
    cmd_cnt   = 4'd0;
    din       = 8'hFF;
    push("held_load", 8'hFF, 1'b0);
    cnt_rdy_low = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) break;
      if (!cmd_ready) cnt_rdy_low++;
    end
    chk("held_ready_low_cycles", 32'(cnt_rdy_low), 32'd4);
    chk("held_done_seen", 32'(done), 32'd1);
    begin
      exp_t e;
      e = sb.pop_front();
      chk({e.tag, "_dout"}, 32'(dout), 32'(e.d));
      chk({e.tag, "_sout"}, 32'(sout), 32'(e.s));
    end
    chk("held_ready_on_done", 32'(cmd_ready), 32'd1);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    wait_done(0, 1'b0);

    push("load_3c", 8'h3C, 1'b0);
    send(OP_LOAD, 4'd0, 8'h3C);
    wait_done(0, 1'b0);
    push("shl0", 8'h3C, 1'b0);
    send(OP_SHL, 4'd0, 8'h00);
    wait_done(0, 1'b0);
    push("clear", 8'h00, 1'b0);
    send(OP_CLEAR, 4'd0, 8'h00);
    wait_done(0, 1'b0);

    // Give sout a 1 first, so CLEAR/LOAD leaving it alone is visible.
    push("load_80", 8'h80, 1'b0);
    send(OP_LOAD, 4'd0, 8'h80);
    wait_done(0, 1'b0);
    push("rol1", 8'h01, 1'b1);
    send(OP_ROL, 4'd1, 8'h00);
    wait_done(1, 1'b0);
    push("clear_keeps_sout", 8'h00, 1'b1);
    send(OP_CLEAR, 4'd0, 8'h00);
    wait_done(0, 1'b0);
    push("hold", 8'h00, 1'b1);
    send(OP_HOLD, 4'd7, 8'h55);
    wait_done(0, 1'b0);

    for (int t = 0; t < 6; t++) begin
      q0  = 8'($urandom);
      op  = rops[$urandom_range(0, 4)];
      n   = $urandom_range(1, 15);
      sin = 1'($urandom);
      push("rnd_load", q0, sout);
      send(OP_LOAD, 4'd0, q0);
      wait_done(0, 1'b0);
      m = model(op, q0, n, sin);
      push($sformatf("rnd%0d_op%0d_n%0d", t, op, n), m[7:0], m[8]);
      send(op, 4'(n), 8'h00);
      wait_done(n, 1'b0);
    end

    // Reset in the middle of SHL 5: immediate clear, and no done afterwards.
    push("load_a5b", 8'hA5, sout);
    send(OP_LOAD, 4'd0, 8'hA5);
    wait_done(0, 1'b0);
    sin = 1'b1;
    send(OP_SHL, 4'd5, 8'h00);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrun_rst_dout", 32'(dout), 32'h00);
    chk("midrun_rst_sout", 32'(sout), 32'd0);
    chk("midrun_rst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    dones = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done) dones++;
    end
    chk("midrun_rst_no_done", 32'(dones), 32'd0);
    chk("midrun_rst_idle_ready", 32'(cmd_ready), 32'd1);
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
